// File: rtl/parity_pkg.sv
// Shared definitions for the parity generator: mode encodings, default width and mode decode.
package parity_pkg;

  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    MODE_EVEN  = 2'b00,
    MODE_ODD   = 2'b01,
    MODE_MARK  = 2'b10,
    MODE_SPACE = 2'b11
  } mode_t;

  // Turns the raw XOR of a word into the parity bit for the selected mode.
  function automatic logic apply_mode(input mode_t mode, input logic x);
    logic p;
    p = x;
    case (mode)
      MODE_EVEN:  p = x;
      MODE_ODD:   p = ~x;
      MODE_MARK:  p = 1'b1;
      MODE_SPACE: p = 1'b0;
      default:    p = x;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/parity_tree.sv
// Combinational XOR reduction of a DATA_W-bit word.
module parity_tree
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] data,
  output logic              x_c
);

  assign x_c = ^data;

endmodule

// File: rtl/parity_gen.sv
// Registered parity generator with selectable even/odd/mark/space mode.
// Optional receive-side checker (parity_err, err_sticky) is compiled in with `define PARITY_CHECK_EN.
module parity_gen
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter logic [1:0]  DEF_MODE = 2'b00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic [1:0]        mode_sel,
  output logic              parity_bit,
  output logic              parity_valid
`ifdef PARITY_CHECK_EN
  ,
  input  logic              rx_parity,
  output logic              parity_err,
  output logic              err_sticky,
  input  logic              err_clr
`endif
);

  logic x_c;
  logic p_c;
  logic bit_d;
  logic valid_d;

  parity_tree #(.DATA_W(DATA_W)) u_tree (
    .data (data_in),
    .x_c  (x_c)
  );

  // An unresolved mode_sel (e.g. left floating) falls back to the integration default mode.
  always_comb begin
    p_c = apply_mode(mode_t'(DEF_MODE), x_c);
    case (mode_sel)
      MODE_EVEN, MODE_ODD, MODE_MARK, MODE_SPACE: p_c = apply_mode(mode_t'(mode_sel), x_c);
      default:                                    p_c = apply_mode(mode_t'(DEF_MODE), x_c);
    endcase
  end

  always_comb begin
    bit_d   = parity_bit;
    valid_d = 1'b0;
    if (data_valid) begin
      bit_d   = p_c;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_bit   <= 1'b0;
      parity_valid <= 1'b0;
    end else begin
      parity_bit   <= bit_d;
      parity_valid <= valid_d;
    end
  end

`ifdef PARITY_CHECK_EN
  logic err_d;
  logic sticky_d;

  // Sticky flag sets together with the error pulse; a coincident clear loses to the set.
  always_comb begin
    err_d    = 1'b0;
    sticky_d = err_sticky & ~err_clr;
    if (data_valid && (p_c != rx_parity)) begin
      err_d    = 1'b1;
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_err <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      parity_err <= err_d;
      err_sticky <= sticky_d;
    end
  end
`endif

endmodule

// File: tb/tb_parity_gen.sv
// Self-checking bench for parity_gen: directed vectors plus randomized traffic against a behavioural model.
module tb_parity_gen;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic [1:0]   mode_sel;
  logic         parity_bit;
  logic         parity_valid;
`ifdef PARITY_CHECK_EN
  logic         rx_parity;
  logic         err_clr;
  logic         parity_err;
  logic         err_sticky;
  logic         exp_err;
  logic         exp_sticky;
`endif

  logic exp_bit;
  logic exp_valid;
  int   total = 0;
  int   bad   = 0;

  parity_gen #(.DATA_W(W), .DEF_MODE(2'b00)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .mode_sel     (mode_sel),
    .parity_bit   (parity_bit),
    .parity_valid (parity_valid)
`ifdef PARITY_CHECK_EN
    ,
    .rx_parity    (rx_parity),
    .parity_err   (parity_err),
    .err_sticky   (err_sticky),
    .err_clr      (err_clr)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: count the ones and apply the mode rule directly.
  function automatic logic ref_parity(input logic [W-1:0] d, input logic [1:0] m);
    int ones;
    ones = $countones(d);
    case (m)
      2'b00:   return (ones % 2) == 1;
      2'b01:   return (ones % 2) == 0;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_outs(input string tag);
    check({tag, "/bit"}, parity_bit, exp_bit);
    check({tag, "/valid"}, parity_valid, exp_valid);
`ifdef PARITY_CHECK_EN
    check({tag, "/err"}, parity_err, exp_err);
    check({tag, "/sticky"}, err_sticky, exp_sticky);
`endif
  endtask

  task automatic model_reset();
    exp_bit   = 1'b0;
    exp_valid = 1'b0;
`ifdef PARITY_CHECK_EN
    exp_err    = 1'b0;
    exp_sticky = 1'b0;
`endif
  endtask

  // Called at a falling edge: drive inputs, advance the model, check after the next rising edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic [1:0] m,
                      input logic rx, input logic clr, input string tag);
    logic p;
    data_valid = v;
    data_in    = d;
    mode_sel   = m;
    p = ref_parity(d, m);
    if (v) exp_bit = p;
    exp_valid = v;
`ifdef PARITY_CHECK_EN
    rx_parity  = rx;
    err_clr    = clr;
    exp_err    = v && (p != rx);
    exp_sticky = exp_err | (exp_sticky & ~clr);
`else
    if (rx && clr) exp_valid = v;
`endif
    @(negedge clk);
    check_outs(tag);
  endtask

  logic [W-1:0] vec31 [6];
  logic         exp31 [6];

  initial begin
    vec31 = '{8'b00110111, 8'b00001111, 8'b10101111, 8'b10101001, 8'b10101001, 8'b10111101};
    exp31 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset held 10 ns with data_valid asserted; outputs must stay 0.
    reset      = 1'b0;
    data_valid = 1'b1;
    data_in    = 8'b00110111;
    mode_sel   = 2'b00;
`ifdef PARITY_CHECK_EN
    rx_parity = 1'b0;
    err_clr   = 1'b0;
`endif
    model_reset();
    #3;
    check_outs("in_reset");
    @(posedge clk);
    #3;
    check_outs("in_reset_edge");
    @(negedge clk);
    reset = 1'b1;

    // First edge after release accepts data; then the even-mode vector table.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, vec31[i], 2'b00, exp31[i], 1'b0, $sformatf("even%0d", i));
      check($sformatf("even_tbl%0d", i), parity_bit, exp31[i]);
    end

    // Odd mode table values.
    step(1'b1, 8'b00110111, 2'b01, 1'b0, 1'b0, "odd0");
    check("odd_tbl0", parity_bit, 1'b0);
    step(1'b1, 8'b00001111, 2'b01, 1'b1, 1'b0, "odd1");
    check("odd_tbl1", parity_bit, 1'b1);

    // Mark and space with arbitrary data.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, W'($urandom), 2'b10, 1'b1, 1'b0, "mark");
      check("mark_one", parity_bit, 1'b1);
      step(1'b1, W'($urandom), 2'b11, 1'b0, 1'b0, "space");
      check("space_zero", parity_bit, 1'b0);
    end

    // Load a 1, then idle with toggling data and mode changes: result holds.
    step(1'b1, 8'b00000001, 2'b00, 1'b1, 1'b0, "pre_idle");
    for (int i = 0; i < 5; i++)
      step(1'b0, W'($urandom), 2'(i), 1'b0, 1'b0, "idle_hold");
    check("idle_held_one", parity_bit, 1'b1);

`ifdef PARITY_CHECK_EN
    // Mismatch pulses once, sticky latches, clear releases; set beats clear.
    step(1'b1, 8'b00110111, 2'b00, 1'b0, 1'b0, "chk_err");
    check("chk_err_pulse", parity_err, 1'b1);
    step(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, "chk_after");
    check("chk_sticky_kept", err_sticky, 1'b1);
    step(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, "chk_clr");
    check("chk_sticky_clr", err_sticky, 1'b0);
    step(1'b1, 8'b00110111, 2'b00, 1'b0, 1'b0, "chk_set");
    step(1'b1, 8'b00110111, 2'b00, 1'b0, 1'b1, "chk_set_clr");
    check("chk_set_wins", err_sticky, 1'b1);
    step(1'b1, 8'b00110111, 2'b00, 1'b1, 1'b0, "chk_match");
`endif

    // Randomized traffic, including back-to-back valid cycles.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), W'($urandom), 2'($urandom), 1'($urandom),
           1'($urandom_range(0, 7) == 0), "rand");

    // Mid-stream reset discards a pending result at once.
    data_valid = 1'b1;
    data_in    = 8'b00000001;
    mode_sel   = 2'b00;
    @(posedge clk);
    #1;
    check("pre_rst_valid", parity_valid, 1'b1);
    reset = 1'b0;
    model_reset();
    #1;
    check_outs("rst_async");
    @(negedge clk);
    @(posedge clk);
    #1;
    check_outs("rst_with_valid");
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 8'b00000011, 2'b01, 1'b1, 1'b0, "post_rst");
    check("post_rst_odd", parity_bit, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
